// File: rtl/t_ff_async_rst_if.sv
// Toggle-register data bundle: toggle requests in, flop state out.
// Optional complement output qn exists only when TFF_QN_EN is defined.
interface t_ff_async_rst_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] q;
`ifdef TFF_QN_EN
   logic [WIDTH-1:0] qn;

   modport master (output t, input  q, input  qn);
   modport slave  (input  t, output q, output qn);
`else
   modport master (output t, input  q);
   modport slave  (input  t, output q);
`endif
endinterface

// File: rtl/t_ff_async_rst.sv
// Bank of WIDTH independent T flip-flops with synchronous active-low reset.
// The "_async_rst" name is historical; the reset is sampled on clk.
// Optional feature macro: TFF_QN_EN adds a registered complement output qn.
module t_ff_async_rst #(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   t_ff_async_rst_if.slave      bus
);
   logic [WIDTH-1:0] q_q, q_d;
`ifdef TFF_QN_EN
   logic [WIDTH-1:0] qn_q, qn_d;
`endif

   // Next state: reset beats toggle; each bit toggles on its own t bit.
   always_comb begin
      q_d = q_q ^ bus.t;
`ifdef TFF_QN_EN
      qn_d = ~(q_q ^ bus.t);
`endif
      if (!rst) begin
         q_d = '0;
`ifdef TFF_QN_EN
         qn_d = '1;
`endif
      end
   end

   // State registers; qn is its own flop so it never has a comb path from q.
   always_ff @(posedge clk) begin
      q_q <= q_d;
`ifdef TFF_QN_EN
      qn_q <= qn_d;
`endif
   end

   assign bus.q = q_q;
`ifdef TFF_QN_EN
   assign bus.qn = qn_q;
`endif
endmodule

// File: tb/tb_t_ff_async_rst.sv
// Directed bench: a single-bit instance and a 4-bit instance on one clock.
module tb_t_ff_async_rst;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   t_ff_async_rst_if #(.WIDTH(1)) ba ();
   t_ff_async_rst_if #(.WIDTH(4)) bb ();

   t_ff_async_rst #(.WIDTH(1)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
   t_ff_async_rst #(.WIDTH(4)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      assert (act === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
   endtask

   // Advance to 2 time units after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst  = 1'b0;
      ba.t = 1'b1;
      bb.t = 4'hF;
      #2;
      // Reset with t high: reset wins
      tick();
      chk("rst_qa", 64'(ba.q), 64'h0);
      chk("rst_qb", 64'(bb.q), 64'h0);
`ifdef TFF_QN_EN
      chk("rst_qna", 64'(ba.qn), 64'h1);
      chk("rst_qnb", 64'(bb.qn), 64'hF);
`endif
      // Hold for 3 edges
      rst  = 1'b1;
      ba.t = 1'b0;
      bb.t = 4'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_qa", 64'(ba.q), 64'h0);
         chk("hold_qb", 64'(bb.q), 64'h0);
      end
      // Continuous toggle: 1,0,1,0
      ba.t = 1'b1;
      tick(); chk("tog1", 64'(ba.q), 64'h1);
      tick(); chk("tog2", 64'(ba.q), 64'h0);
      tick(); chk("tog3", 64'(ba.q), 64'h1);
`ifdef TFF_QN_EN
      chk("tog3_qn", 64'(ba.qn), 64'h0);
`endif
      tick(); chk("tog4", 64'(ba.q), 64'h0);
      tick(); chk("tog5", 64'(ba.q), 64'h1);
      // Mid-run reset: q holds until next edge, then clears even with t=1
      rst = 1'b0;
      #3;
      chk("midrst_hold", 64'(ba.q), 64'h1);
      #1;
      tick(); chk("midrst_clr", 64'(ba.q), 64'h0);
      tick(); chk("midrst_stay", 64'(ba.q), 64'h0);
`ifdef TFF_QN_EN
      chk("midrst_qn", 64'(ba.qn), 64'h1);
`endif
      // Release with t=1: first edge with rst high toggles
      rst = 1'b1;
      #3;
      chk("rel_pre", 64'(ba.q), 64'h0);
      #1;
      tick(); chk("rel_tog", 64'(ba.q), 64'h1);
      // Width-4 behaviour
      rst = 1'b0;
      tick(); chk("w4_rst", 64'(bb.q), 64'h0);
      rst  = 1'b1;
      ba.t = 1'b0;
      bb.t = 4'b1010;
      tick(); chk("w4_a", 64'(bb.q), 64'hA);
      tick(); chk("w4_b", 64'(bb.q), 64'h0);
      bb.t = 4'b0110;
      tick(); chk("w4_c", 64'(bb.q), 64'h6);
`ifdef TFF_QN_EN
      chk("w4_qn", 64'(bb.qn), 64'h9);
`endif
      chk("w4_qa_hold", 64'(ba.q), 64'h0);
      bb.t = 4'b0011;
      tick(); chk("w4_d", 64'(bb.q), 64'h5);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
